// File: rtl/nbit_regfile.sv
// Multi-entry register file: one write port, two registered read ports with
// write-to-read bypass, per-entry valid bits and a synchronous clear.
module nbit_regfile #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEnA,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  output logic              RdValidA,
  input  logic              RdEnB,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              RdValidB
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_ok;
  logic             rd_ok_a;
  logic             rd_ok_b;
  logic [WIDTH-1:0] data_nxt_a;
  logic             valid_nxt_a;
  logic [WIDTH-1:0] data_nxt_b;
  logic             valid_nxt_b;

  assign wr_ok   = WrEn && (32'(WrAddr) < DEPTH);
  assign rd_ok_a = 32'(RdAddrA) < DEPTH;
  assign rd_ok_b = 32'(RdAddrB) < DEPTH;

  // Storage array and valid vector
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (Clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (wr_ok) begin
      mem[WrAddr]   <= WrData;
      valid[WrAddr] <= 1'b1;
    end
  end

  // Read-port next values; a same-edge write to the read address is bypassed
  always_comb begin
    data_nxt_a  = '0;
    valid_nxt_a = 1'b0;
    data_nxt_b  = '0;
    valid_nxt_b = 1'b0;
    if (wr_ok && (WrAddr == RdAddrA)) begin
      data_nxt_a  = WrData;
      valid_nxt_a = 1'b1;
    end else if (rd_ok_a) begin
      data_nxt_a  = mem[RdAddrA];
      valid_nxt_a = valid[RdAddrA];
    end
    if (wr_ok && (WrAddr == RdAddrB)) begin
      data_nxt_b  = WrData;
      valid_nxt_b = 1'b1;
    end else if (rd_ok_b) begin
      data_nxt_b  = mem[RdAddrB];
      valid_nxt_b = valid[RdAddrB];
    end
  end

  // Output registers hold their value while the read strobe is low
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RdDataA  <= '0;
      RdValidA <= 1'b0;
      RdDataB  <= '0;
      RdValidB <= 1'b0;
    end else if (Clr) begin
      RdDataA  <= '0;
      RdValidA <= 1'b0;
      RdDataB  <= '0;
      RdValidB <= 1'b0;
    end else begin
      if (RdEnA) begin
        RdDataA  <= data_nxt_a;
        RdValidA <= valid_nxt_a;
      end
      if (RdEnB) begin
        RdDataB  <= data_nxt_b;
        RdValidB <= valid_nxt_b;
      end
    end
  end

endmodule

// File: doc/nbit_regfile.md
# nbit_regfile

Parametrised multi-entry register file for the ALU datapath, generalising the single n-bit enable register into DEPTH entries of WIDTH bits. It has one write port and two independently enabled, registered read ports, so both ALU operands can be fetched in the same cycle. Write-to-read bypass, per-entry valid tracking and a synchronous clear are included. Unlike a bare enable register, every entry and every output holds its value when not written; no output ever goes to X.

## Interface
- WIDTH, 4, data width of each entry (≥1)
- DEPTH, 8, number of entries (≥2, ≤2^ADDR_W)
- ADDR_W, 3, address width
- Clk  input  1  clock, rising-edge
- Rst  input  1  reset, asynchronous, active-high
- Clr  input  1  synchronous clear of all entries and valid bits
- WrEn  input  1  write strobe
- WrAddr  input  ADDR_W  write address
- WrData  input  WIDTH  write data
- RdEnA  input  1  read-A strobe
- RdAddrA  input  ADDR_W  read-A address
- RdDataA  output  WIDTH  registered read-A data
- RdValidA  output  1  registered valid bit of the entry read on port A
- RdEnB / RdAddrB / RdDataB / RdValidB  same as port A, independent

## Operation
- Storage: DEPTH × WIDTH entries plus a DEPTH-bit valid vector.
- Write: on a rising edge with WrEn=1, Clr=0 and WrAddr<DEPTH:
  - entry[WrAddr] ← WrData
  - valid[WrAddr] ← 1
- Out-of-range write (WrAddr ≥ DEPTH): ignored, no state change.
- Clear: on a rising edge with Clr=1:
  - all entries ← 0, all valid ← 0
  - RdDataA/B ← 0, RdValidA/B ← 0
  - Clr overrides any concurrent write or read.
- Read port X (A or B): on a rising edge with RdEnX=1 and Clr=0:
  - if WrEn=1 and WrAddr==RdAddrX<DEPTH: bypass, RdDataX ← WrData and RdValidX ← 1 (the new value is returned).
  - else if RdAddrX<DEPTH: RdDataX ← entry[RdAddrX], RdValidX ← valid[RdAddrX].
  - else (out of range): RdDataX ← 0, RdValidX ← 0.
- RdEnX=0: RdDataX and RdValidX hold their previous values.
- Ports A and B may read the same address in the same cycle; both return identical data.
- Entries not written hold their value indefinitely.

## Timing
- Reset (Rst=1, asynchronous): all entries 0, valid vector 0, RdDataA=RdDataB=0, RdValidA=RdValidB=0 immediately. Rst overrides all other inputs.
- First edge after Rst deasserts operates normally.
- Write latency: data is stored at edge N and is readable through the array from a read issued at edge N+1.
- Read latency: 1 cycle. RdEnX sampled at edge N gives RdDataX valid after edge N.
- Bypass: a read and a write to the same address at the same edge return the written data at that edge, with no stale value.
- Reset asserted mid-sequence discards all contents. A write or read in progress at the edge coincident with Rst has no effect.
- Throughput: one write plus two reads every cycle, no stalls.

## Test plan
- Reset then read all addresses: RdEnA=RdEnB=1 sweeping 0..7 → RdData=0 and RdValid=0 for every address.
- Write entry 3 ← 4'hA, then read A@3 and B@3 next cycle → both RdData=4'hA, RdValid=1. Read A@2 → RdData=0, RdValid=0.
- Same-edge bypass: entry 5 holds 4'h1; WrEn with WrAddr=5, WrData=4'h7 and RdEnA with RdAddrA=5 at the same edge → RdDataA=4'h7, RdValidA=1.
- Hold: after reading 4'hA on port A, deassert RdEnA and write entry 3 ← 4'h2 → RdDataA stays 4'hA until the next RdEnA.
- Clear wins over write: fill entries 0..7, then assert Clr together with WrEn (addr 1, data 4'hF) → all reads return 0 with RdValid=0, and RdDataA/B are 0 right after the Clr edge.
- Out of range (DEPTH=6, ADDR_W=3): write to address 7 is ignored; read of address 6 → RdData=0, RdValid=0. Then assert Rst asynchronously mid-write → outputs go to 0 immediately, before the next clock edge.
